// File: rtl/sr_fetch_queue.sv
// sr_fetch_queue: sequential instruction fetch unit with a DEPTH-entry
// prefetch queue between the schoolRISCV core and the instruction cache.
// One cache request may be outstanding. Each in-flight request reserves a
// queue slot, so a returning response always has room.
// Optional feature macro: SR_FETCH_BYPASS_EN. When defined, a response that
// arrives while the queue is empty goes straight to the core in the same
// cycle. When undefined, every instruction passes through the queue.
module sr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     im_req,
  output logic [31:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic                     im_drdy,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Fetch control state
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   req_pc_reg;
  logic          pending_reg;
  logic          drop_reg;

  // Queue state
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [DEPTH-1:0] wr_en;

  // Per-cycle events
  logic          resp_valid;
  logic          resp_keep;
  logic          q_empty;
  logic          issue;
  logic          push;
  logic          pop_head;
  logic [CW:0]   occupancy;

  // The two low bits of the redirect target are discarded by design.
  logic          unused_redirect_bits;
  assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

  // A response only counts when a request is actually outstanding.
  assign resp_valid = im_drdy && pending_reg && !rst;
  // A counted response is delivered unless it belongs to a flushed stream
  // or arrives in the very cycle of a redirect.
  assign resp_keep  = resp_valid && !drop_reg && !redirect;
  assign q_empty    = (count_reg == '0);

  // Occupancy includes the in-flight request so its response has a slot.
  assign occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, pending_reg};
  assign issue      = !rst && !redirect && (!pending_reg || im_drdy) &&
                      (occupancy < (CW+1)'(DEPTH));

  assign im_req     = issue;
  assign im_addr    = {2'b00, fetch_pc_reg[31:2]};
  assign q_count    = count_reg;

  // Only a real queue entry can be popped; a bypassed instruction never
  // enters the queue.
  assign pop_head   = !q_empty && instr_ready;

`ifdef SR_FETCH_BYPASS_EN
  // A bypassed instruction the core takes immediately is never stored.
  assign push = resp_keep && !(q_empty && instr_ready);
`else
  assign push = resp_keep;
`endif

  // Core-facing head: the queue head, or the live response when bypassing
  always_comb begin
    instr_valid = !q_empty;
    instr       = mem_instr[rd_ptr_reg];
    instr_pc    = mem_pc[rd_ptr_reg];
`ifdef SR_FETCH_BYPASS_EN
    if (q_empty && resp_keep) begin
      instr_valid = 1'b1;
      instr       = im_data;
      instr_pc    = req_pc_reg;
    end
`endif
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop_head})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Decode the write pointer into one write strobe per entry
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Entry storage: {pc, instr} written at the tail, no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_pc[i]    <= req_pc_reg;
        mem_instr[i] <= im_data;
      end
    end
  end

  // Fetch sequencing and queue bookkeeping; redirect overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      pending_reg  <= 1'b0;
      drop_reg     <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (redirect) begin
      fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      if (resp_valid) begin
        // The in-flight response arrived now and is thrown away here.
        pending_reg <= 1'b0;
        drop_reg    <= 1'b0;
      end else if (pending_reg) begin
        // The stale response is still coming; discard it when it lands.
        drop_reg <= 1'b1;
      end
    end else begin
      if (issue) begin
        req_pc_reg   <= fetch_pc_reg;
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
        pending_reg  <= 1'b1;
      end else if (resp_valid) begin
        pending_reg <= 1'b0;
      end
      if (resp_valid && drop_reg) begin
        drop_reg <= 1'b0;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_head) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_sr_fetch_queue.sv
// tb_sr_fetch_queue: directed bench for sr_fetch_queue (DEPTH=4,
// RESET_PC=0x100). A small cache model answers requests after a settable
// latency; a manual mode lets the bench place im_drdy pulses by hand.
// Expected latencies depend on SR_FETCH_BYPASS_EN.
module tb_sr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef SR_FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        im_drdy;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;

  // Cache model / manual response drive
  logic        cache_en;
  logic        man_drdy;
  logic [31:0] man_data;
  int          c_lat;
  int          c_cnt;
  logic [31:0] c_addr;

  int n_tests;
  int n_fail;

  sr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_data(im_data), .im_drdy(im_drdy),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency cache: response c_lat cycles after the request
  initial begin
    c_cnt  = 0;
    c_addr = 32'h0;
  end
  always @(posedge clk) begin
    if (im_req) begin
      c_cnt  <= c_lat;
      c_addr <= im_addr;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
    end
  end
  assign im_drdy = cache_en ? (c_cnt == 1) : man_drdy;
  assign im_data = cache_en ? {8'hA5, c_addr[23:0]} : man_data;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return {8'hA5, pc[25:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Hold reset for 4 cycles, check reset outputs, release; returns in the
  // first cycle with rst low, after outputs settle.
  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    man_drdy = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_im_addr", im_addr, RPC >> 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int nreq;
    int w;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    man_drdy    = 1'b0;
    man_data    = 32'h0;
    cache_en    = 1'b1;
    c_lat       = 1;

    // 1) 1-cycle cache, core always ready: one instruction per cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      chk("t1_im_req", 32'(im_req), 32'd1);
      chk("t1_im_addr", im_addr, 32'h40 + 32'(k));
      if (k >= 2 - BYP) begin
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_pc", instr_pc, RPC + 32'(4 * (k - 2 + BYP)));
        chk("t1_instr", instr, exp_instr(RPC + 32'(4 * (k - 2 + BYP))));
        chk("t1_q_count", 32'(q_count), 32'(1 - BYP));
      end else begin
        chk("t1_valid_lat", 32'(instr_valid), 32'd0);
      end
      $display("[TB] t1 cycle %0d im_addr=%h valid=%0d pc=%h", k, im_addr, instr_valid, instr_pc);
    end

    // 2) Core stalled: exactly DEPTH requests, then drain in order
    instr_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      if (im_req) nreq++;
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    next_cycle();
    chk("t2_full_count", 32'(q_count), 32'd4);
    chk("t2_full_req", 32'(im_req), 32'd0);
    chk("t2_full_valid", 32'(instr_valid), 32'd1);
    $display("[TB] t2 full: requests=%0d q_count=%0d", nreq, q_count);
    instr_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) next_cycle();
      chk("t2_drain_valid", 32'(instr_valid), 32'd1);
      chk("t2_drain_pc", instr_pc, RPC + 32'(4 * j));
      chk("t2_drain_instr", instr, exp_instr(RPC + 32'(4 * j)));
      $display("[TB] t2 drain %0d pc=%h instr=%h", j, instr_pc, instr);
    end

    // 3) Latency 3, redirect while the 0x108 fetch is in flight
    c_lat = 3;
    do_reset();
    repeat (8) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    #1;
    chk("t3_redir_req", 32'(im_req), 32'd0);
    chk("t3_redir_count", 32'(q_count), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("t3_new_req", 32'(im_req), 32'd1);
    chk("t3_new_addr", im_addr, 32'h80);
    chk("t3_drop_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    chk("t3_after_count", 32'(q_count), 32'd0);
    chk("t3_after_valid", 32'(instr_valid), 32'd0);
    w = 0;
    while (!instr_valid && w < 8) begin
      next_cycle();
      w++;
    end
    chk("t3_wait", 32'(w), 32'(3 - BYP));
    chk("t3_pc", instr_pc, 32'h200);
    chk("t3_instr", instr, exp_instr(32'h200));
    $display("[TB] t3 after redirect: waited=%0d pc=%h", w, instr_pc);

    // 4) Redirect coinciding with im_drdy and instr_ready
    cache_en    = 1'b0;
    instr_ready = 1'b0;
    do_reset();
    chk("t4_req0", 32'(im_req), 32'd1);
    @(negedge clk);
    man_drdy = 1'b1;
    man_data = 32'h1111_0001;
    #1;
    chk("t4_req1_addr", im_addr, 32'h41);
    @(negedge clk);
    man_drdy = 1'b0;
    #1;
    chk("t4_head_pc", instr_pc, 32'h100);
    chk("t4_head_instr", instr, 32'h1111_0001);
    chk("t4_head_count", 32'(q_count), 32'd1);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    man_drdy    = 1'b1;
    man_data    = 32'h2222_0002;
    instr_ready = 1'b1;
    #1;
    chk("t4_redir_req", 32'(im_req), 32'd0);
    chk("t4_redir_valid", 32'(instr_valid), 32'd1);
    chk("t4_redir_pc", instr_pc, 32'h100);
    @(negedge clk);
    redirect    = 1'b0;
    man_drdy    = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("t4_flush_count", 32'(q_count), 32'd0);
    chk("t4_flush_valid", 32'(instr_valid), 32'd0);
    chk("t4_restart_req", 32'(im_req), 32'd1);
    chk("t4_restart_addr", im_addr, 32'hC0);
    @(negedge clk);
    man_drdy = 1'b1;
    man_data = 32'h3333_0003;
    #1;
    chk("t4_resp_valid", 32'(instr_valid), 32'(BYP));
    @(negedge clk);
    man_drdy = 1'b0;
    #1;
    chk("t4_kept_valid", 32'(instr_valid), 32'd1);
    chk("t4_kept_pc", instr_pc, 32'h300);
    chk("t4_kept_instr", instr, 32'h3333_0003);
    chk("t4_kept_count", 32'(q_count), 32'd1);
    $display("[TB] t4 post-redirect pc=%h instr=%h", instr_pc, instr);

    // 5) PC wrap at 0xFFFF_FFFC and spurious im_drdy
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    #1;
    chk("t5_redir_req", 32'(im_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("t5_top_req", 32'(im_req), 32'd1);
    chk("t5_top_addr", im_addr, 32'h3FFF_FFFF);
    next_cycle();
    chk("t5_pend_req", 32'(im_req), 32'd0);
    man_drdy = 1'b1;
    man_data = 32'h4444_0004;
    #1;
    chk("t5_wrap_req", 32'(im_req), 32'd1);
    chk("t5_wrap_addr", im_addr, 32'h0);
    @(negedge clk);
    man_drdy = 1'b0;
    #1;
    chk("t5_top_pc", instr_pc, 32'hFFFF_FFFC);
    chk("t5_count1", 32'(q_count), 32'd1);
    @(negedge clk);
    man_drdy = 1'b1;
    man_data = 32'h5555_0005;
    @(negedge clk);
    man_data = 32'h6666_0006;
    #1;
    chk("t5_count2", 32'(q_count), 32'd2);
    @(negedge clk);
    man_data = 32'h7777_0007;
    #1;
    chk("t5_full_stop_req", 32'(im_req), 32'd0);
    @(negedge clk);
    man_data = 32'hDEAD_BEEF;
    #1;
    chk("t5_spur_count", 32'(q_count), 32'd4);
    chk("t5_spur_req", 32'(im_req), 32'd0);
    @(negedge clk);
    man_drdy = 1'b0;
    #1;
    chk("t5_after_spur_count", 32'(q_count), 32'd4);
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) next_cycle();
      chk("t5_drain_pc", instr_pc, 32'hFFFF_FFFC + 32'(4 * j));
      $display("[TB] t5 drain %0d pc=%h instr=%h", j, instr_pc, instr);
    end
    chk("t5_last_instr", instr, 32'h7777_0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/sr_fetch_queue.md
# sr_fetch_queue

Parametrised instruction fetch unit with a prefetch queue, sitting between the schoolRISCV core and the instruction cache. It issues sequential word fetches over the `im_req`/`im_drdy` handshake, buffers up to `DEPTH` returned instructions with their PCs, and presents them to the core through a valid/ready interface. A redirect input (branch taken) flushes the queue, cancels any in-flight response and restarts fetch at a new PC.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: byte address of the first fetch after reset; bits [1:0] are zero.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `im_req`  out  1  fetch request strobe; one cycle per request.
- `im_addr`  out  32  word address of the request (`fetch_pc >> 2`).
- `im_data`  in  32  returned instruction; valid when `im_drdy`=1.
- `im_drdy`  in  1  response strobe; at least one cycle after the matching `im_req`.
- `instr_valid`  out  1  queue head (or bypass) holds an instruction.
- `instr`  out  32  head instruction.
- `instr_pc`  out  32  byte PC of `instr`.
- `instr_ready`  in  1  core consumes the head this cycle if `instr_valid`=1.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new byte PC; bits [1:0] ignored and treated as zero.
- `q_count`  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- State: `fetch_pc` (next byte PC to request), `req_pc` (PC of in-flight request), `pending`, `drop`, circular buffer of `DEPTH` {pc, instr} entries, read/write pointers, `count`.
- At most one request outstanding.
- Issue condition: `!rst && !redirect && (!pending || im_drdy) && (count + pending) < DEPTH`. The in-flight request reserves one slot, so a response always finds room.
- On issue: `im_req`=1, `im_addr`=`fetch_pc>>2`, `req_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc+4` (mod 2^32 wrap), `pending`←1.
- On `im_drdy` with `pending`=1:
  - `pending` clears unless a new request issues in the same cycle.
  - If `drop`=0, {`req_pc`, `im_data`} is pushed.
  - If `drop`=1, the response is discarded and `drop`←0.
- `im_drdy` with `pending`=0 is ignored.
- Pop: `instr_valid && instr_ready` advances the read pointer. Push and pop in the same cycle leave `count` unchanged.
- Redirect has priority over every other event in its cycle:
  - Queue is emptied and pointers reset.
  - `fetch_pc`←`{redirect_pc[31:2],2'b00}`.
  - A response arriving in that same cycle is discarded.
  - If `pending`=1 and `im_drdy`=0, `drop`←1.
  - No request issues in the redirect cycle.
  - A pop in the redirect cycle is still honoured: the core already took the head.
- Queue outputs are valid only while `count`≠0; `instr`/`instr_pc` are don't-care otherwise.

## Timing
- Reset values:
  - `im_req`=0, `instr_valid`=0, `q_count`=0.
  - `fetch_pc`=`RESET_PC`, `pending`=0, `drop`=0.
  - `im_addr`=`RESET_PC>>2`.
- First request: the cycle after `rst` deasserts.
- `im_req`/`im_addr` and `instr_*` are combinational from registered state (plus the bypass path). No combinational path from `instr_ready` to `im_req`.
- Request at cycle T with `im_drdy` at T+L (L≥1): `instr_valid` at T+L+1 (no bypass).
- With a 1-cycle cache and continuous `instr_ready`: one instruction per cycle, because issue overlaps response.
- After redirect at cycle R: first new request at R+1.
- `rst` asserted mid-operation: all state returns to reset values next edge. An outstanding response after reset is ignored (`pending`=0).

## Configuration
- `SR_FETCH_BYPASS_EN` defined:
  - When `count`=0 and a non-dropped response arrives, `instr_valid`=1 in the same cycle, with `instr`=`im_data` and `instr_pc`=`req_pc`.
  - If `instr_ready`=1 the entry is not written; otherwise it is pushed normally.
  - Gives a fetch-to-core latency of L.
- Undefined: all instructions pass through the queue; latency L+1; no combinational path from `im_data` to `instr`.

## Test plan
- Reset, `RESET_PC`=0x100, 1-cycle cache, `instr_ready`=1:
  - `im_addr` sequence 0x40, 0x41, 0x42…
  - `instr_pc` sequence 0x100, 0x104, 0x108, one instruction per cycle after fill.
- `instr_ready`=0, `DEPTH`=4: exactly 4 requests issue, `q_count`=4, `im_req` stays 0. Raising `instr_ready` drains entries in order.
- Cache latency 3, redirect to 0x200 while a request to 0x108 is pending: the 0x108 response is dropped, `q_count`=0, and the next `instr_pc` is 0x200.
- Redirect in the same cycle as `im_drdy` and `instr_ready`: head popped, response discarded, no request issued that cycle, `drop` stays 0.
- `fetch_pc`=0xFFFF_FFFC: next request wraps to `im_addr`=0. Also, `im_drdy` pulsed with no pending request leaves `q_count` unchanged.
- With and without `SR_FETCH_BYPASS_EN`, 1-cycle cache from empty: `instr_valid` follows `im_drdy` in the same cycle vs. one cycle later; instruction stream identical.
